// File: rtl/wbuff_bank_dbuf.sv
// wbuff_bank_dbuf: weight bank with load sequencer, BPE encoder and shadow/active tap registers.
module BPEB_Enc_ETC #(
  parameter int WEIGHT_WIDTH = 16,
  parameter int BPR_WIDTH    = ((WEIGHT_WIDTH+1)/2)*3,
  parameter int ETC_WIDTH    = 4
) (
  input  logic [WEIGHT_WIDTH-1:0] w,
  input  logic [3:0]              n_ap,
  output logic [BPR_WIDTH-1:0]    bpr,
  output logic [ETC_WIDTH-1:0]    etc
);
  localparam int ND = BPR_WIDTH/3;
  logic [2*ND:0] ext;
  assign ext = {(2*ND)'(signed'(w)), 1'b0};
  // Radix-4 Booth digits as {neg, two, one}; the n_ap lowest digits are dropped
  always_comb begin
    logic [2:0] trip, d;
    bpr = '0;
    etc = '0;
    for (int i = 0; i < ND; i++) begin
      trip = ext[2*i+2 -: 3];
      d = (trip == 3'b001 || trip == 3'b010) ? 3'b001 :
          trip == 3'b011 ? 3'b010 :
          trip == 3'b100 ? 3'b110 :
          (trip == 3'b101 || trip == 3'b110) ? 3'b101 : 3'b000;
      d = i < int'(n_ap) ? 3'b000 : d;
      bpr[3*i +: 3] = d;
      etc = etc + ETC_WIDTH'(d != 3'b000);
    end
  end
endmodule

module wbuff_bank_dbuf #(
  parameter int NB_TAPS       = 11,
  parameter int WEIGHT_WIDTH  = 16,
  parameter int ETC_WIDTH     = 4,
  parameter int BPR_WIDTH     = ((WEIGHT_WIDTH+1)/2)*3,
  parameter int DEPTH         = 72,
  parameter int ADDR_WIDTH    = $clog2(DEPTH),
  parameter int TAP_CNT_WIDTH = $clog2(NB_TAPS+1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [ADDR_WIDTH-1:0]         wr_addr,
  input  logic [WEIGHT_WIDTH-1:0]       wr_data,
  input  logic                          ext_rd_en,
  input  logic [ADDR_WIDTH-1:0]         ext_rd_addr,
  output logic [WEIGHT_WIDTH-1:0]       rd_data,
  output logic                          ext_rd_valid,
  input  logic                          start,
  input  logic [ADDR_WIDTH-1:0]         base_addr,
  input  logic [TAP_CNT_WIDTH-1:0]      num_taps,
  input  logic [3:0]                    n_ap,
  input  logic                          swap,
  input  logic                          clear_all_wregs,
  output logic                          busy,
  output logic                          shadow_valid,
  output logic                          load_done,
  output logic [NB_TAPS*WEIGHT_WIDTH-1:0] WRegs,
  output logic [NB_TAPS*BPR_WIDTH-1:0]    WBPRs,
  output logic [NB_TAPS*ETC_WIDTH-1:0]    WETCs
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  state_t state;
  logic [WEIGHT_WIDTH-1:0] mem [DEPTH];
  logic [WEIGHT_WIDTH-1:0] sh_w [NB_TAPS];
  logic [WEIGHT_WIDTH-1:0] act_w [NB_TAPS];
  logic [BPR_WIDTH-1:0] sh_b [NB_TAPS];
  logic [BPR_WIDTH-1:0] act_b [NB_TAPS];
  logic [ETC_WIDTH-1:0] sh_e [NB_TAPS];
  logic [ETC_WIDTH-1:0] act_e [NB_TAPS];
  logic [ADDR_WIDTH-1:0] addr_q, rd_addr;
  logic [TAP_CNT_WIDTH-1:0] k, n_lat, wr_idx, n_eff;
  logic [3:0] nap_q;
  logic [BPR_WIDTH-1:0] enc_b;
  logic [ETC_WIDTH-1:0] enc_e;
  logic wr_pend, swap_ok, start_ok, rd_en;
  assign busy = state != IDLE;
  assign swap_ok = swap & shadow_valid;
  assign start_ok = start & ~busy & (~shadow_valid | swap_ok);
  assign n_eff = num_taps == '0 ? TAP_CNT_WIDTH'(1) :
                 num_taps > TAP_CNT_WIDTH'(NB_TAPS) ? TAP_CNT_WIDTH'(NB_TAPS) : num_taps;
  // The sequencer owns the read port for the whole load, drain included
  assign rd_en = state == READ || (ext_rd_en && !busy);
  assign rd_addr = busy ? addr_q : ext_rd_addr;
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
      ext_rd_valid <= 1'b0;
    end else begin
      if (rd_en) rd_data <= mem[rd_addr];
      ext_rd_valid <= ext_rd_en & ~busy;
    end
  end
  BPEB_Enc_ETC #(
    .WEIGHT_WIDTH(WEIGHT_WIDTH),
    .BPR_WIDTH(BPR_WIDTH),
    .ETC_WIDTH(ETC_WIDTH)
  ) u_enc (
    .w(rd_data),
    .n_ap(nap_q),
    .bpr(enc_b),
    .etc(enc_e)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr_q <= '0;
      k <= '0;
      n_lat <= '0;
      wr_idx <= '0;
      nap_q <= '0;
      wr_pend <= 1'b0;
      shadow_valid <= 1'b0;
      load_done <= 1'b0;
      for (int t = 0; t < NB_TAPS; t++) begin
        sh_w[t] <= '0;
        sh_b[t] <= '0;
        sh_e[t] <= '0;
        act_w[t] <= '0;
        act_b[t] <= '0;
        act_e[t] <= '0;
      end
    end else begin
      state <= start_ok ? READ :
               (state == READ && k == n_lat - 1'b1) ? DRAIN :
               state == DRAIN ? IDLE : state;
      load_done <= state == DRAIN;
      wr_pend <= state == READ;
      wr_idx <= k;
      if (start_ok) begin
        addr_q <= base_addr;
        n_lat <= n_eff;
        nap_q <= n_ap;
        k <= '0;
      end else if (state == READ) begin
        addr_q <= addr_q == ADDR_WIDTH'(DEPTH-1) ? '0 : addr_q + 1'b1;
        k <= k + 1'b1;
      end
      if (state == DRAIN) shadow_valid <= 1'b1;
      else if (swap_ok) shadow_valid <= 1'b0;
      for (int t = 0; t < NB_TAPS; t++) begin
        if (start_ok) begin
          sh_w[t] <= '0;
          sh_b[t] <= '0;
          sh_e[t] <= '0;
        end else if (wr_pend && wr_idx == TAP_CNT_WIDTH'(t)) begin
          sh_w[t] <= rd_data;
          sh_b[t] <= enc_b;
          sh_e[t] <= enc_e;
        end
        if (clear_all_wregs) begin
          act_w[t] <= '0;
          act_b[t] <= '0;
          act_e[t] <= '0;
        end else if (swap_ok) begin
          act_w[t] <= sh_w[t];
          act_b[t] <= sh_b[t];
          act_e[t] <= sh_e[t];
        end
      end
    end
  end
  for (genvar t = 0; t < NB_TAPS; t++) begin : g_pack
    assign WRegs[(t+1)*WEIGHT_WIDTH-1 -: WEIGHT_WIDTH] = act_w[t];
    assign WBPRs[(t+1)*BPR_WIDTH-1 -: BPR_WIDTH] = act_b[t];
    assign WETCs[(t+1)*ETC_WIDTH-1 -: ETC_WIDTH] = act_e[t];
  end
endmodule
